// File: rtl/rle_unzigzag.sv
// Run-length expander and inverse scan feeding the 2D IDCT coefficient RAM.
// Define RLE_UNZIGZAG_ALT_SCAN_EN to add the alt_scan input (MPEG-2 alternate scan).
module rle_unzigzag #(
    parameter int LEVEL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    // A symbol transfers on a rising edge where sym_valid and sym_ready are both high;
    // the source must hold run/level/eob stable while sym_valid is high and sym_ready is low.
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [5:0]         run,
    input  logic [LEVEL_W-1:0] level,
    input  logic               eob,
    input  logic               idct_rdy,
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
    input  logic               alt_scan,
`endif
    output logic [5:0]         iaddr,
    output logic [LEVEL_W-1:0] idata,
    output logic               iwren,
    output logic               idct_en,
    output logic               err,
    output logic               busy,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_FLUSH   = 3'd1,
        S_START   = 3'd2,
        S_WAIT_LO = 3'd3,
        S_WAIT_HI = 3'd4
    } state_t;

    // Scan position -> raster address.
    localparam logic [5:0] SCAN_ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    state_t             state_q, state_d;
    logic [6:0]         pos_q, pos_d;
    logic [5:0]         zcnt_q, zcnt_d;
    logic               loaded_q, loaded_d;
    logic               err_q, err_d;
    logic               write_due;
    logic [LEVEL_W-1:0] wdata;

`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
    localparam logic [5:0] SCAN_ALT [64] = '{
         0,  8, 16, 24,  1,  9,  2, 10, 17, 25, 32, 40, 48, 56, 57, 49,
        41, 33, 26, 18,  3, 11,  4, 12, 19, 27, 34, 42, 50, 58, 35, 43,
        51, 59, 20, 28,  5, 13,  6, 14, 21, 29, 36, 44, 52, 60, 37, 45,
        53, 61, 22, 30,  7, 15, 23, 31, 38, 46, 54, 62, 39, 47, 55, 63
    };
    logic alt_q, alt_d;
    assign iaddr = alt_q ? SCAN_ALT[pos_q[5:0]] : SCAN_ZZ[pos_q[5:0]];
`else
    assign iaddr = SCAN_ZZ[pos_q[5:0]];
`endif

    assign err       = err_q;
    assign busy      = !(state_q == S_FILL && pos_q == 7'd0);
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT_HI;
            pos_q    <= 7'd0;
            zcnt_q   <= 6'd0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
            alt_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            zcnt_q   <= zcnt_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
            alt_q    <= alt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        zcnt_d    = zcnt_q;
        loaded_d  = loaded_q;
        err_d     = err_q;
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
        alt_d     = alt_q;
`endif
        sym_ready = 1'b0;
        iwren     = 1'b0;
        idata     = '0;
        idct_en   = 1'b0;
        write_due = 1'b0;
        wdata     = '0;

        case (state_q)
            S_FILL: begin
                if (idct_rdy) begin
                    if (zcnt_q != 6'd0) begin
                        write_due = 1'b1;
                        zcnt_d    = zcnt_q - 6'd1;
                    end else if (sym_valid && eob) begin
                        sym_ready = 1'b1;
                        loaded_d  = 1'b0;
                        state_d   = S_FLUSH;
                    end else if (sym_valid && !loaded_q) begin
                        // First cycle of a symbol only captures its run; the level follows the zeros.
                        zcnt_d   = run;
                        loaded_d = 1'b1;
                    end else if (sym_valid) begin
                        write_due = 1'b1;
                        wdata     = level;
                        sym_ready = 1'b1;
                        loaded_d  = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                if (pos_q[6]) begin
                    state_d = S_START;
                end else begin
                    iwren = 1'b1;
                    pos_d = pos_q + 7'd1;
                end
            end
            S_START: begin
                idct_en = 1'b1;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!idct_rdy) state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (idct_rdy) begin
                    state_d  = S_FILL;
                    pos_d    = 7'd0;
                    zcnt_d   = 6'd0;
                    loaded_d = 1'b0;
                    err_d    = 1'b0;
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
                    alt_d    = alt_scan;
`endif
                end
            end
            default: state_d = S_WAIT_HI;
        endcase

        // Writes past the last scan position are dropped and flagged for the rest of the block.
        if (write_due) begin
            if (pos_q[6]) begin
                err_d = 1'b1;
            end else begin
                iwren = 1'b1;
                idata = wdata;
                pos_d = pos_q + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_rle_unzigzag.sv
// Bench for rle_unzigzag: directed and random blocks against a coefficient-list model.
// Builds with or without RLE_UNZIGZAG_ALT_SCAN_EN.
module tb_rle_unzigzag;

    localparam int LW = 8;
    localparam int EW = 6 + LW;

    logic          clk = 1'b0;
    logic          reset;
    logic          sym_valid;
    logic          sym_ready;
    logic [5:0]    run;
    logic [LW-1:0] level;
    logic          eob;
    logic          idct_rdy;
    logic [5:0]    iaddr;
    logic [LW-1:0] idata;
    logic          iwren;
    logic          idct_en;
    logic          err;
    logic          busy;
    logic [2:0]    dbg_state;
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
    logic          alt_scan;
    int alt_tab[64] = '{
         0,  8, 16, 24,  1,  9,  2, 10, 17, 25, 32, 40, 48, 56, 57, 49,
        41, 33, 26, 18,  3, 11,  4, 12, 19, 27, 34, 42, 50, 58, 35, 43,
        51, 59, 20, 28,  5, 13,  6, 14, 21, 29, 36, 44, 52, 60, 37, 45,
        53, 61, 22, 30,  7, 15, 23, 31, 38, 46, 54, 62, 39, 47, 55, 63
    };
`endif

    rle_unzigzag #(.LEVEL_W(LW)) dut (
        .clk(clk), .reset(reset),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .run(run), .level(level), .eob(eob), .idct_rdy(idct_rdy),
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
        .alt_scan(alt_scan),
`endif
        .iaddr(iaddr), .idata(idata), .iwren(iwren), .idct_en(idct_en),
        .err(err), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic          exp_err_q[$];
    int            zz[64];
    int            blk_run[$];
    logic [LW-1:0] blk_lvl[$];
    logic          blk_alt;
    logic          last_err;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [63:0]   wmask;
    int            wcount;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: expand symbols into a scan-order coefficient list, truncate to 64.
    task automatic push_block();
        logic [LW-1:0] coef[$];
        int a;
        for (int i = 0; i < blk_run.size(); i++) begin
            for (int z = 0; z < blk_run[i]; z++) coef.push_back('0);
            coef.push_back(blk_lvl[i]);
        end
        last_err = (coef.size() > 64);
        for (int p = 0; p < 64; p++) begin
            a = zz[p];
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
            if (blk_alt) a = alt_tab[p];
`endif
            exp_q.push_back({6'(a), (p < coef.size()) ? coef[p] : LW'(0)});
        end
        exp_err_q.push_back(last_err);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            wmask  = '0;
            wcount = 0;
        end else begin
            if (iwren) begin
                if (exp_q.size() == 0) fail_now("unexpected_write");
                else check("write_addr_data", {18'd0, iaddr, idata}, {18'd0, exp_q.pop_front()});
                wmask[iaddr] = 1'b1;
                wcount++;
            end
            if (idct_en) begin
                if (exp_err_q.size() == 0) begin
                    fail_now("unexpected_idct_en");
                end else begin
                    check("err_at_start", {31'd0, err}, {31'd0, exp_err_q.pop_front()});
                    check("writes_left_at_start", exp_q.size(), 0);
                    check("write_count", wcount, 64);
                    check("addr_cover_lo", wmask[31:0], 32'hFFFF_FFFF);
                    check("addr_cover_hi", wmask[63:32], 32'hFFFF_FFFF);
                end
                wmask  = '0;
                wcount = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_stall(input int n);
        idct_rdy = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("stall_no_iwren", {31'd0, iwren}, 0);
            check("stall_no_ready", {31'd0, sym_ready}, 0);
            @(posedge clk); #1;
        end
        idct_rdy = 1'b1;
    endtask

    task automatic send_sym(input logic [5:0] r, input logic [LW-1:0] l, input logic e, input int stall_at);
        bit done = 0;
        int cyc = 0;
        run = r; level = l; eob = e; sym_valid = 1'b1;
        while (!done) begin
            if (cyc == stall_at) do_stall(10);
            else if (stall_at < 0 && $urandom_range(0, 15) == 0) do_stall($urandom_range(1, 6));
            @(negedge clk);
            done = sym_ready;
            @(posedge clk); #1;
            cyc++;
            if (!done && cyc > 300) begin
                fail_now("symbol_timeout");
                done = 1;
            end
        end
        sym_valid = 1'b0;
    endtask

    task automatic run_block(input int stall_sym, input int stall_at);
        bit got = 0;
        int hold;
        push_block();
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
        alt_scan = blk_alt;
`endif
        idct_rdy = 1'b1;
        @(posedge clk); #1;
        check("fill_entry_err", {31'd0, err}, 0);
        check("fill_entry_busy", {31'd0, busy}, 0);
        for (int i = 0; i < blk_run.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send_sym(6'(blk_run[i]), blk_lvl[i], 1'b0, (i == stall_sym) ? stall_at : -1);
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
            alt_scan = 1'($urandom);
`endif
        end
        send_sym(6'd0, '0, 1'b1, -1);
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = idct_en;
        end
        if (!got) fail_now("idct_en_timeout");
        @(posedge clk); #1;
        // Offer a symbol while the IDCT runs; it must not be taken until idct_rdy drops and returns.
        sym_valid = 1'b1; eob = 1'b1;
        hold = $urandom_range(0, 3);
        repeat (hold) begin
            @(negedge clk);
            check("wait_no_ready", {31'd0, sym_ready}, 0);
            check("err_held", {31'd0, err}, {31'd0, last_err});
            @(posedge clk); #1;
        end
        idct_rdy = 1'b0;
        repeat ($urandom_range(1, 5)) begin
            @(negedge clk);
            check("wait_no_ready", {31'd0, sym_ready}, 0);
            check("wait_busy", {31'd0, busy}, 1);
            check("err_held", {31'd0, err}, {31'd0, last_err});
            @(posedge clk); #1;
        end
        sym_valid = 1'b0; eob = 1'b0;
    endtask

    task automatic gen_random();
        int n;
        blk_run.delete();
        blk_lvl.delete();
        n = $urandom_range(0, 10);
        for (int i = 0; i < n; i++) begin
            blk_run.push_back(($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 8));
            blk_lvl.push_back(LW'($urandom_range(0, 255)));
        end
        blk_alt = 1'b0;
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
        blk_alt = 1'($urandom);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p, lo, hi;
        p = 0;
        // Zigzag built by walking anti-diagonals, alternating direction.
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz[p] = r * 8 + (s - r); p++; end
            else            for (int r = lo; r <= hi; r++) begin zz[p] = r * 8 + (s - r); p++; end
        end

        reset = 1'b1; sym_valid = 1'b0; run = '0; level = '0; eob = 1'b0; idct_rdy = 1'b0;
        blk_alt = 1'b0; last_err = 1'b0;
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
        alt_scan = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_sym_ready", {31'd0, sym_ready}, 0);
        check("rst_iwren", {31'd0, iwren}, 0);
        check("rst_idct_en", {31'd0, idct_en}, 0);
        check("rst_iaddr", {26'd0, iaddr}, 0);
        check("rst_idata", {24'd0, idata}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_busy", {31'd0, busy}, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        blk_run = '{0, 1};  blk_lvl = '{8'd5, 8'hFD}; run_block(-1, -1);
        blk_run.delete();   blk_lvl.delete();         run_block(-1, -1);
        blk_run = '{63};    blk_lvl = '{8'd7};        run_block(-1, -1);
        blk_run = '{60, 5}; blk_lvl = '{8'd1, 8'd2};  run_block(-1, -1);
        blk_run = '{20, 3}; blk_lvl = '{8'd4, 8'h81}; run_block(0, 5);
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
        blk_alt = 1'b1;
        blk_run = '{0, 0, 0, 0}; blk_lvl = '{8'd1, 8'd2, 8'd3, 8'd4}; run_block(-1, -1);
        blk_alt = 1'b0;
`endif
        for (int b = 0; b < 25; b++) begin
            gen_random();
            run_block(-1, -1);
        end

        // Reset in the middle of a zero run.
        blk_run = '{30}; blk_lvl = '{8'd9}; blk_alt = 1'b0;
        push_block();
`ifdef RLE_UNZIGZAG_ALT_SCAN_EN
        alt_scan = 1'b0;
`endif
        idct_rdy = 1'b1;
        @(posedge clk); #1;
        run = 6'd30; level = 8'd9; eob = 1'b0; sym_valid = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("pre_reset_iwren", {31'd0, iwren}, 1);
        reset = 1'b1;
        #1;
        check("midrst_iwren", {31'd0, iwren}, 0);
        check("midrst_sym_ready", {31'd0, sym_ready}, 0);
        check("midrst_idct_en", {31'd0, idct_en}, 0);
        check("midrst_err", {31'd0, err}, 0);
        check("midrst_busy", {31'd0, busy}, 1);
        sym_valid = 1'b0; idct_rdy = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        exp_err_q.delete();
        reset = 1'b0;
        @(posedge clk); #1;
        gen_random();
        run_block(-1, -1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rle_unzigzag.md
Name: rle_unzigzag

Overview:
- Upstream feeder for the 2D IDCT stage in the MPEG2 decode path.
- Consumes (run, level, eob) symbols from the VLC decoder and expands run-length zeros.
- Maps each scan position through the inverse zigzag scan and writes all 64 coefficients into the IDCT input port.
- Pulses the IDCT enable once the block is complete, then waits for the IDCT to finish before accepting the next block.

Parameters:
- LEVEL_W, 8, signed level width; must equal the IDCT idata width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- sym_valid  input  1  symbol present on run/level/eob
- sym_ready  output  1  symbol consumed this cycle
- run  input  6  zero coefficients preceding level
- level  input  LEVEL_W  signed coefficient value
- eob  input  1  end-of-block marker; run/level ignored
- idct_rdy  input  1  IDCT idle and accepting writes
- iaddr  output  6  raster coefficient address to IDCT
- idata  output  LEVEL_W  coefficient to IDCT
- iwren  output  1  IDCT write strobe
- idct_en  output  1  one-cycle start pulse to IDCT
- err  output  1  sticky per-block run overflow flag
- busy  output  1  high in any state other than FILL with pos==0

Behaviour:
- Reset (asynchronous): state=WAIT_HI, pos=0, zcnt=0, err=0. All strobes (sym_ready, iwren, idct_en) low; iaddr=0, idata=0.
- pos is a 7-bit scan position (0..64). zcnt holds the remaining zeros of the current run.
- iaddr = scan_table[pos[5:0]]. Outputs are combinational from state, pos and inputs. Writes take effect at the IDCT on the same edge.
- FILL state:
  - No symbol work happens while idct_rdy=0 (stall).
  - If zcnt>0: iwren=1, idata=0, pos++, zcnt--, sym_ready=0.
  - Else if sym_valid & eob: sym_ready=1, go to FLUSH.
  - Else if sym_valid & zcnt==0 & loaded==0: latch zcnt=run, set loaded=1, no write, sym_ready=0.
  - Else if sym_valid & loaded & zcnt==0: iwren=1, idata=level, pos++, sym_ready=1, clear loaded.
  - Cost per symbol: run+2 cycles (one load cycle, run zero writes, one level write). EOB costs 1 cycle.
- Overflow: if a write is due when pos==64, suppress iwren, set err=1, and still handshake the symbol (sym_ready=1 on its level cycle). Discard continues until EOB.
- FLUSH state: iwren=1, idata=0 while pos<64, pos++. When pos==64, go to START without a write.
- START state: idct_en=1 for exactly one cycle, then go to WAIT_LO.
- WAIT_LO state: wait for idct_rdy==0, then go to WAIT_HI.
- WAIT_HI state: wait for idct_rdy==1, then go to FILL with pos=0, zcnt=0, loaded=0, err=0.
- err holds through START/WAIT until the next FILL entry.
- EOB with pos==0 (empty block): FLUSH writes 64 zeros.
- EOB arriving while zcnt>0 is impossible (sym_ready is low during zero writes).
- Reset mid-block: abandons the block. The IDCT RAM may contain a partial block, which is overwritten fully by the next block.
- Every block writes each of the 64 addresses exactly once (when err=0).

Optional Feature:
- Macro: RLE_UNZIGZAG_ALT_SCAN_EN.
- When defined:
  - Adds input port alt_scan (1 bit), sampled on FILL entry and held for the block.
  - alt_scan=1 selects the MPEG-2 alternate scan table (0,8,16,24,1,9,2,10,17,25,32,...).
  - alt_scan=0 selects the standard zigzag table (0,1,8,16,9,2,3,10,...).
- When undefined: no port; standard zigzag only.

Test Plan:
- Symbols (0,5),(1,-3),EOB with idct_rdy=1:
  - writes idata=5 @iaddr0, 0 @1, -3 @8;
  - then 61 zero writes covering every remaining address;
  - single idct_en pulse; err=0.
- EOB only → 64 zero writes, each address 0..63 hit once; idct_en pulse 65 cycles after EOB acceptance.
- (63,7),EOB → 63 zeros, then 7 @iaddr=63 (scan pos 63); FLUSH writes nothing; idct_en follows.
- (60,1),(5,2),EOB → second level suppressed, err=1 held until next FILL, exactly 64 writes, idct_en still pulsed.
- Hold idct_rdy=0 for 10 cycles mid-run → no iwren and no sym_ready during the stall; resumes at the same pos. After idct_en, a new symbol is not accepted until idct_rdy goes 0 then 1.
- RLE_UNZIGZAG_ALT_SCAN_EN defined, alt_scan=1, (0,1),(0,2),(0,3),(0,4),EOB → writes to iaddr 0,8,16,24; assert reset mid-FILL → state WAIT_HI, strobes low immediately.
